fir_mac_filter: RTL

Time-multiplexed, parametrised FIR filter that replaces the fixed 32-tap parallel filter at the front of the FAS datapath. It accepts one sample per valid/ready handshake and computes the dot product over a sample delay line with a single multiplier across TAPS cycles. The coefficients are runtime-writable. The result is rounded and narrowed, then presented on a valid/ready output that feeds the serial-to-parallel/FFT stage.

---
 rtl/fir_mac_filter_if.sv | 33 +++
 rtl/fir_mac_filter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/fir_mac_filter_if.sv
// fir_mac_filter_if: sample-in, coefficient-write and result-out bundle for fir_mac_filter.
// Latency: none, wires only.
// Backpressure: in_ready throttles samples; out_ready holds the result.
// Ports: in_valid/in_ready/in_data, coef_we/coef_addr/coef_wdata, out_valid/out_ready/out_data.
// slave is the filter side; master is the upstream/downstream side.
interface fir_mac_filter_if #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 32,
  parameter int OUT_W  = 16
);
  localparam int AW = $clog2(TAPS);

  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic                     coef_we;
  logic [AW-1:0]            coef_addr;
  logic signed [COEF_W-1:0] coef_wdata;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [OUT_W-1:0]  out_data;

  modport slave (
    input  in_valid, in_data, coef_we, coef_addr, coef_wdata, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, coef_we, coef_addr, coef_wdata, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/fir_mac_filter.sv
// fir_mac_filter: time-multiplexed FIR, one multiplier shared over TAPS cycles per accepted sample.
// Latency: result valid TAPS+1 cycles after the accept cycle; the first TAPS-1 samples after reset/clear give none.
// Backpressure: result held in OUT with in_ready low until out_ready; coefficient writes only land in IDLE.
// Ports: clk, rst (async, active-low), clear (IDLE only), busy (MAC/OUT), bus (fir_mac_filter_if.slave).
// Build option: define FIR_SAT_EN to clamp the rounded result to OUT_W; otherwise it wraps.
module fir_mac_filter #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int FRAC_W = 15,
  parameter int TAPS   = 32,
  parameter int OUT_W  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  output logic            busy,
  fir_mac_filter_if.slave bus
);
  localparam int AW    = $clog2(TAPS);
  localparam int FW    = $clog2(TAPS + 1);
  localparam int PW    = DATA_W + COEF_W;
  localparam int ACC_W = PW + AW;

  // Half an output LSB, added before the arithmetic shift: round half toward +inf.
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(1) << (FRAC_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

  state_t                   state_q, state_d;
  logic signed [DATA_W-1:0] x_q [TAPS];
  logic signed [DATA_W-1:0] x_d [TAPS];
  logic signed [COEF_W-1:0] c_q [TAPS];
  logic signed [COEF_W-1:0] c_d [TAPS];
  logic [FW-1:0]            fill_q, fill_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [AW-1:0]            k_q, k_d;
  logic                     in_ready_q, in_ready_d;
  logic                     out_valid_q, out_valid_d;
  logic                     busy_q, busy_d;
  logic signed [OUT_W-1:0]  out_data_q, out_data_d;

  logic signed [PW-1:0]     prod;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W-1:0]  sum_rnd;
  logic signed [ACC_W-1:0]  rnd;
  logic signed [OUT_W-1:0]  narrowed;

`ifdef FIR_SAT_EN
  localparam logic signed [ACC_W-1:0] OUT_MAX =
    $signed({{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;

  always_comb begin
    if (rnd > OUT_MAX)      narrowed = OUT_MAX[OUT_W-1:0];
    else if (rnd < OUT_MIN) narrowed = OUT_MIN[OUT_W-1:0];
    else                    narrowed = rnd[OUT_W-1:0];
  end
`else
  // Plain two's-complement wrap: the upper bits are simply discarded.
  logic unused_rnd_hi;
  assign unused_rnd_hi = ^rnd[ACC_W-1:OUT_W];

  always_comb begin
    narrowed = rnd[OUT_W-1:0];
  end
`endif

  always_comb begin
    // Datapath: the current term folded into the running sum, plus the final
    // rounding of that sum, which is only captured on the last MAC cycle.
    prod    = PW'(x_q[k_q]) * PW'(c_q[k_q]);
    sum     = acc_q + {{AW{prod[PW-1]}}, prod};
    sum_rnd = sum + RND;
    rnd     = sum_rnd >>> FRAC_W;

    state_d    = state_q;
    x_d        = x_q;
    c_d        = c_q;
    fill_d     = fill_q;
    acc_d      = acc_q;
    k_d        = k_q;
    out_data_d = out_data_q;

    case (state_q)
      S_IDLE: begin
        // A write in the accept cycle lands before MAC reads c_q, so the
        // new coefficient already applies to this sample.
        if (bus.coef_we && ({1'b0, bus.coef_addr} < (AW+1)'(TAPS))) begin
          c_d[bus.coef_addr] = bus.coef_wdata;
        end
        if (bus.in_valid) begin
          for (int i = TAPS - 1; i > 0; i--) begin
            x_d[i] = x_q[i-1];
          end
          x_d[0] = bus.in_data;
          if (fill_q != FW'(TAPS)) fill_d = fill_q + FW'(1);
          acc_d   = '0;
          k_d     = '0;
          state_d = S_MAC;
        end else if (clear) begin
          for (int i = 0; i < TAPS; i++) begin
            x_d[i] = '0;
          end
          fill_d = '0;
        end
      end
      S_MAC: begin
        acc_d = sum;
        k_d   = k_q + AW'(1);
        if (k_q == AW'(TAPS - 1)) begin
          // fill_q already counts this sample; a partial line is a warm-up
          // result and is dropped.
          if (fill_q == FW'(TAPS)) begin
            state_d    = S_OUT;
            out_data_d = narrowed;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_OUT: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered decodes of the next state.
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_OUT);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      for (int i = 0; i < TAPS; i++) begin
        x_q[i] <= '0;
        c_q[i] <= '0;
      end
      fill_q      <= '0;
      acc_q       <= '0;
      k_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      c_q         <= c_d;
      fill_q      <= fill_d;
      acc_q       <= acc_d;
      k_q         <= k_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign busy          = busy_q;

endmodule
